// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared state encoding, frame terminators and clog2 helper for the ADC scan controller
package adc_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_TERM_CR = 3'd3,
    ST_TERM_LF = 3'd4
  } scan_state_t;

  localparam logic [7:0] CR_CHAR = 8'h0D;
  localparam logic [7:0] LF_CHAR = 8'h0A;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_fifo.sv
// rtl/adc_scan_ctrl_fifo.sv - single-clock FIFO with registered read, level/empty/full and drop-on-full flag
module scan_sync_fifo #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               wr_drop
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_wr;
  logic               do_rd;

  assign empty   = (level == '0);
  assign full    = level[FIFO_AW];
  // A write against a full FIFO is dropped even if a pop happens the same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign wr_drop = wr_en && full;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - masked analog-mux scan controller framing each scan with CR,LF into a readout FIFO
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CH_NUM     = 32,
  parameter int ADDR_W     = 5,
  parameter int SETTLE_CYC = 5000000,
  parameter int SCANS      = 1,
  parameter int FIFO_AW    = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CH_NUM-1:0]  ch_mask,
  input  logic [DATA_W-1:0]  adc_data,
  output logic [ADDR_W-1:0]  adc_addr,
  output logic               smp_stb,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int CNT_W  = clog2(SETTLE_CYC + 1);
  localparam int SCAN_W = clog2(SCANS + 2);

  scan_state_t       state, state_nx;
  logic [CH_NUM-1:0] mask_q;
  logic [CNT_W-1:0]  settle_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [ADDR_W-1:0] first_start, first_mask, next_ch;
  logic              next_found;
  logic              start_ok, settle_done, scan_last;
  logic              wr_en, wr_drop;
  logic [DATA_W-1:0] wr_data;

  assign start_ok    = (state == ST_IDLE) && start && (ch_mask != '0);
  assign settle_done = (settle_cnt == CNT_W'(SETTLE_CYC - 1));
  assign scan_last   = (SCANS != 0) && (scan_cnt == SCAN_W'(SCANS - 1));
  assign busy        = (state != ST_IDLE);

  // Descending loop so the last hit is the lowest qualifying channel.
  always_comb begin
    first_start = '0;
    first_mask  = '0;
    next_ch     = '0;
    next_found  = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_start = ADDR_W'(i);
      if (mask_q[i]) begin
        first_mask = ADDR_W'(i);
        if (ADDR_W'(i) > adc_addr) begin
          next_ch    = ADDR_W'(i);
          next_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start_ok) state_nx = ST_SETTLE;
      ST_SETTLE:  if (settle_done) state_nx = ST_SAMPLE;
      ST_SAMPLE:  state_nx = next_found ? ST_SETTLE : ST_TERM_CR;
      ST_TERM_CR: state_nx = ST_TERM_LF;
      ST_TERM_LF: state_nx = scan_last ? ST_IDLE : ST_SETTLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (stop && (state != ST_IDLE)) state_nx = ST_IDLE;
  end

  always_comb begin
    smp_stb = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state)
      ST_SAMPLE: begin
        smp_stb = 1'b1;
        wr_en   = 1'b1;
        wr_data = adc_data;
      end
      ST_TERM_CR: begin
        wr_en   = 1'b1;
        wr_data = DATA_W'(CR_CHAR);
      end
      ST_TERM_LF: begin
        wr_en   = 1'b1;
        wr_data = DATA_W'(LF_CHAR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adc_addr   <= '0;
      mask_q     <= '0;
      settle_cnt <= '0;
      scan_cnt   <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= (state != ST_IDLE) && (state_nx == ST_IDLE);
      if (start_ok)     overflow <= 1'b0;
      else if (wr_drop) overflow <= 1'b1;
      case (state)
        ST_IDLE: if (start_ok) begin
          mask_q     <= ch_mask;
          scan_cnt   <= '0;
          settle_cnt <= '0;
          adc_addr   <= first_start;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + CNT_W'(1);
        ST_SAMPLE: begin
          settle_cnt <= '0;
          if (next_found) adc_addr <= next_ch;
        end
        ST_TERM_LF: begin
          scan_cnt <= scan_cnt + SCAN_W'(1);
          adc_addr <= first_mask;
        end
        default: ;
      endcase
    end
  end

  scan_sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .wr_drop (wr_drop)
  );

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - directed bench for adc_scan_ctrl: single-scan, continuous and small-FIFO instances
module tb_adc_scan_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // a: SCANS=1 depth 16, b: continuous depth 16, c: SCANS=1 depth 4
  logic       start_a = 0, stop_a = 0, rd_en_a = 0;
  logic [3:0] ch_mask_a = '0;
  logic [7:0] adc_data_a, rd_data_a;
  logic [1:0] adc_addr_a;
  logic       smp_stb_a, empty_a, full_a, busy_a, done_a, overflow_a;
  logic [4:0] level_a;

  logic       start_b = 0, stop_b = 0, rd_en_b = 0;
  logic [3:0] ch_mask_b = '0;
  logic [7:0] adc_data_b, rd_data_b;
  logic [1:0] adc_addr_b;
  logic       smp_stb_b, empty_b, full_b, busy_b, done_b, overflow_b;
  logic [4:0] level_b;

  logic       start_c = 0, stop_c = 0, rd_en_c = 0;
  logic [3:0] ch_mask_c = '0;
  logic [7:0] adc_data_c, rd_data_c;
  logic [1:0] adc_addr_c;
  logic       smp_stb_c, empty_c, full_c, busy_c, done_c, overflow_c;
  logic [2:0] level_c;

  assign adc_data_a = 8'h10 + {6'b0, adc_addr_a};
  assign adc_data_b = 8'h10 + {6'b0, adc_addr_b};
  assign adc_data_c = 8'h10 + {6'b0, adc_addr_c};

  adc_scan_ctrl #(.DATA_W(8), .CH_NUM(4), .ADDR_W(2), .SETTLE_CYC(3), .SCANS(1), .FIFO_AW(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .ch_mask(ch_mask_a),
    .adc_data(adc_data_a), .adc_addr(adc_addr_a), .smp_stb(smp_stb_a), .rd_en(rd_en_a),
    .rd_data(rd_data_a), .empty(empty_a), .full(full_a), .level(level_a), .busy(busy_a),
    .done(done_a), .overflow(overflow_a));

  adc_scan_ctrl #(.DATA_W(8), .CH_NUM(4), .ADDR_W(2), .SETTLE_CYC(3), .SCANS(0), .FIFO_AW(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .ch_mask(ch_mask_b),
    .adc_data(adc_data_b), .adc_addr(adc_addr_b), .smp_stb(smp_stb_b), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .empty(empty_b), .full(full_b), .level(level_b), .busy(busy_b),
    .done(done_b), .overflow(overflow_b));

  adc_scan_ctrl #(.DATA_W(8), .CH_NUM(4), .ADDR_W(2), .SETTLE_CYC(3), .SCANS(1), .FIFO_AW(2)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .stop(stop_c), .ch_mask(ch_mask_c),
    .adc_data(adc_data_c), .adc_addr(adc_addr_c), .smp_stb(smp_stb_c), .rd_en(rd_en_c),
    .rd_data(rd_data_c), .empty(empty_c), .full(full_c), .level(level_c), .busy(busy_c),
    .done(done_c), .overflow(overflow_c));

  int cyc = 0;
  int done_cnt_a = 0, done_cnt_b = 0, cap_b = 0, bad_addr_a = 0;
  logic [1:0] smp_addr_a [$];
  int         smp_cyc_a [$];

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (smp_stb_b) cap_b++;
      if (smp_stb_a) begin
        smp_addr_a.push_back(adc_addr_a);
        smp_cyc_a.push_back(cyc);
      end
      if (busy_a && !ch_mask_a[adc_addr_a]) bad_addr_a++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input int which, input string tag, input logic [7:0] exp);
    case (which)
      0: rd_en_a = 1'b1;
      1: rd_en_b = 1'b1;
      default: rd_en_c = 1'b1;
    endcase
    tick();
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    rd_en_c = 1'b0;
    case (which)
      0: check(tag, {24'b0, rd_data_a}, {24'b0, exp});
      1: check(tag, {24'b0, rd_data_b}, {24'b0, exp});
      default: check(tag, {24'b0, rd_data_c}, {24'b0, exp});
    endcase
  endtask

  logic [7:0] exp_full [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h0D, 8'h0A};
  logic [7:0] exp_odd  [4] = '{8'h11, 8'h13, 8'h0D, 8'h0A};
  logic [7:0] exp_stop [9] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h0D, 8'h0A, 8'h10, 8'h11, 8'h12};

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_addr", {30'b0, adc_addr_a}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_done", {31'b0, done_a}, 32'd0);
    check("rst_ovf", {31'b0, overflow_a}, 32'd0);
    check("rst_empty", {31'b0, empty_a}, 32'd1);
    check("rst_level", {27'b0, level_a}, 32'd0);
    check("rst_rd_data", {24'b0, rd_data_a}, 32'd0);

    // full-mask single scan
    ch_mask_a = 4'b1111;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("s1_busy", {31'b0, busy_a}, 32'd1);
    for (int i = 0; i < 200 && !done_a; i++) tick();
    check("s1_done_seen", {31'b0, done_a}, 32'd1);
    check("s1_busy_end", {31'b0, busy_a}, 32'd0);
    tick();
    check("s1_done_pulse", {31'b0, done_a}, 32'd0);
    check("s1_done_cnt", done_cnt_a, 32'd1);
    check("s1_level", {27'b0, level_a}, 32'd6);
    check("s1_smp_n", smp_addr_a.size(), 32'd4);
    for (int i = 0; i < 6; i++) pop_check(0, $sformatf("s1_word%0d", i), exp_full[i]);
    check("s1_empty", {31'b0, empty_a}, 32'd1);

    // zero mask start is ignored
    ch_mask_a = 4'b0000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    check("zmask_busy", {31'b0, busy_a}, 32'd0);
    check("zmask_done_cnt", done_cnt_a, 32'd1);

    // sparse mask: channels 1 and 3 only
    smp_addr_a.delete();
    smp_cyc_a.delete();
    ch_mask_a = 4'b1010;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("s2_first_addr", {30'b0, adc_addr_a}, 32'd1);
    for (int i = 0; i < 200 && !done_a; i++) tick();
    check("s2_done_seen", {31'b0, done_a}, 32'd1);
    tick();
    check("s2_smp_n", smp_addr_a.size(), 32'd2);
    if (smp_addr_a.size() == 2) begin
      check("s2_smp_addr0", {30'b0, smp_addr_a[0]}, 32'd1);
      check("s2_smp_addr1", {30'b0, smp_addr_a[1]}, 32'd3);
      check("s2_smp_gap", smp_cyc_a[1] - smp_cyc_a[0], 32'd4);
    end
    check("s2_bad_addr", bad_addr_a, 32'd0);
    for (int i = 0; i < 4; i++) pop_check(0, $sformatf("s2_word%0d", i), exp_odd[i]);

    // continuous mode; start+stop together while idle: start wins
    ch_mask_b = 4'b1111;
    start_b = 1'b1;
    stop_b = 1'b1;
    tick();
    start_b = 1'b0;
    stop_b = 1'b0;
    check("s3_start_wins", {31'b0, busy_b}, 32'd1);
    for (int i = 0; i < 200 && cap_b < 7; i++) tick();
    check("s3_caps", cap_b, 32'd7);
    stop_b = 1'b1;
    tick();
    stop_b = 1'b0;
    check("s3_busy_after_stop", {31'b0, busy_b}, 32'd0);
    check("s3_done", {31'b0, done_b}, 32'd1);
    tick();
    check("s3_done_pulse", {31'b0, done_b}, 32'd0);
    check("s3_done_cnt", done_cnt_b, 32'd1);
    repeat (10) tick();
    check("s3_caps_after", cap_b, 32'd7);
    check("s3_level", {27'b0, level_b}, 32'd9);
    for (int i = 0; i < 9; i++) pop_check(1, $sformatf("s3_word%0d", i), exp_stop[i]);
    check("s3_empty", {31'b0, empty_b}, 32'd1);

    // small FIFO overflow, then simultaneous push/pop
    ch_mask_c = 4'b1111;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int i = 0; i < 200 && !done_c; i++) tick();
    check("s4_done_seen", {31'b0, done_c}, 32'd1);
    check("s4_level", {29'b0, level_c}, 32'd4);
    check("s4_full", {31'b0, full_c}, 32'd1);
    check("s4_ovf", {31'b0, overflow_c}, 32'd1);
    pop_check(2, "s4_word0", 8'h10);
    pop_check(2, "s4_word1", 8'h11);
    check("s4_level2", {29'b0, level_c}, 32'd2);
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("s4_ovf_clear", {31'b0, overflow_c}, 32'd0);
    for (int i = 0; i < 50 && !smp_stb_c; i++) tick();
    check("s4_smp_seen", {31'b0, smp_stb_c}, 32'd1);
    pop_check(2, "s4_rw_data", 8'h12);
    check("s4_rw_level", {29'b0, level_c}, 32'd2);
    for (int i = 0; i < 200 && !done_c; i++) tick();
    check("s4_done2", {31'b0, done_c}, 32'd1);

    // reset during SETTLE with data in the FIFO
    ch_mask_a = 4'b1110;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 50 && level_a != 5'd1; i++) tick();
    check("s5_level_pre", {27'b0, level_a}, 32'd1);
    check("s5_addr_pre", {30'b0, adc_addr_a}, 32'd2);
    reset = 1'b1;
    tick();
    check("s5_addr", {30'b0, adc_addr_a}, 32'd0);
    check("s5_busy", {31'b0, busy_a}, 32'd0);
    check("s5_smp", {31'b0, smp_stb_a}, 32'd0);
    check("s5_done", {31'b0, done_a}, 32'd0);
    check("s5_ovf", {31'b0, overflow_a}, 32'd0);
    check("s5_empty", {31'b0, empty_a}, 32'd1);
    check("s5_level", {27'b0, level_a}, 32'd0);
    check("s5_rd_data", {24'b0, rd_data_a}, 32'd0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
